v810_intctl: RTL and testbench

Parametrised interrupt controller that sits in front of the V810 core's interrupt/exception multiplexer. It accepts NCH external request lines, each configurable as edge- or level-triggered and individually maskable, and arbitrates them by programmable 4-bit priority. It drives the core's single INT / INTVn[3:0] pair and tracks which channel the core accepted. An optional in-service stack supports nested interrupts: only strictly higher-priority requests preempt, and end-of-interrupt retires them.

---
 rtl/v810_intctl.sv | 164 ++++++++++++++++
 tb/tb_v810_intctl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v810_intctl.sv
// v810_intctl: NCH-channel edge/level interrupt controller with 4-bit priority arbitration
// driving the V810 INT/INTVn pair. Define V810_INTCTL_NEST_EN to add the nesting in-service stack.
module v810_intctl #(
    parameter  int NCH = 8,
    localparam int CW  = $clog2(NCH)
) (
    input  logic             CLK,
    input  logic             RESn,
    input  logic             CE,
    input  logic [NCH-1:0]   IRQ,
    input  logic [NCH-1:0]   EDGE,
    input  logic [NCH-1:0]   MASK,
    input  logic [4*NCH-1:0] PRIO,
    input  logic             ACK,
    input  logic             EOI,
    output logic             INT,
    output logic [3:0]       INTVn,
    output logic [CW-1:0]    ACT_CH,
    output logic [NCH-1:0]   PEND
);

    logic [NCH-1:0] irq_q, irq_d;
    logic           armed_q, armed_d;
    logic [NCH-1:0] pend_edge_q, pend_edge_d;
    logic           int_q, int_d;
    logic [3:0]     intvn_q, intvn_d;
    logic [CW-1:0]  win_ch_q, win_ch_d;
    logic [CW-1:0]  act_ch_q, act_ch_d;

    logic [NCH-1:0] pend;
    logic [NCH-1:0] elig;
    logic [NCH-1:0] edge_set;
    logic [NCH-1:0] ack_clr;
    logic           ack_ok;
    logic           any_elig;
    logic [CW-1:0]  best_ch;
    logic [3:0]     best_prio;

`ifdef V810_INTCTL_NEST_EN
    logic [15:0]    isr_q, isr_d;
    logic           isr_any;
    logic [3:0]     isr_top;
    logic [3:0]     win_prio;
`else
    logic           eoi_unused;
    assign eoi_unused = EOI;
`endif

    // Level channels follow the sampled line; edge channels use the latched bit.
    assign pend   = (EDGE & pend_edge_q) | (~EDGE & irq_q);
    assign ack_ok = CE & ACK & int_q;

    // armed_q stays low until the first CE edge after reset, so a line already
    // high at reset release is absorbed into irq_q rather than seen as an edge.
    assign edge_set = armed_q ? (IRQ & ~irq_q & EDGE) : '0;

    always_comb begin
        ack_clr = '0;
        if (ack_ok) begin
            ack_clr[win_ch_q] = 1'b1;
        end
    end

`ifdef V810_INTCTL_NEST_EN
    always_comb begin
        isr_any = |isr_q;
        isr_top = '0;
        for (int l = 0; l < 16; l++) begin
            if (isr_q[l]) begin
                isr_top = 4'(l);
            end
        end
    end
`endif

    // Strict '>' while scanning upward keeps the lowest index on a priority tie.
    always_comb begin
        elig = pend & ~MASK;
`ifdef V810_INTCTL_NEST_EN
        for (int i = 0; i < NCH; i++) begin
            if (isr_any && (PRIO[4*i +: 4] <= isr_top)) begin
                elig[i] = 1'b0;
            end
        end
`endif
        any_elig  = 1'b0;
        best_ch   = '0;
        best_prio = '0;
        for (int i = 0; i < NCH; i++) begin
            if (elig[i] && (!any_elig || (PRIO[4*i +: 4] > best_prio))) begin
                any_elig  = 1'b1;
                best_ch   = CW'(i);
                best_prio = PRIO[4*i +: 4];
            end
        end
    end

    always_comb begin
        irq_d       = irq_q;
        armed_d     = armed_q;
        pend_edge_d = pend_edge_q;
        int_d       = int_q;
        intvn_d     = intvn_q;
        win_ch_d    = win_ch_q;
        act_ch_d    = act_ch_q;
        if (CE) begin
            irq_d       = IRQ;
            armed_d     = 1'b1;
            pend_edge_d = (pend_edge_q & ~ack_clr) | edge_set;
            int_d       = any_elig;
            win_ch_d    = best_ch;
            intvn_d     = any_elig ? ~best_prio : 4'hF;
            if (ack_ok) begin
                act_ch_d = win_ch_q;
            end
        end
    end

`ifdef V810_INTCTL_NEST_EN
    // EOI retires the current top level before an ACK on the same edge pushes.
    always_comb begin
        isr_d    = isr_q;
        win_prio = PRIO[{win_ch_q, 2'b00} +: 4];
        if (CE && EOI && isr_any) begin
            isr_d[isr_top] = 1'b0;
        end
        if (ack_ok) begin
            isr_d[win_prio] = 1'b1;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            irq_q       <= '0;
            armed_q     <= 1'b0;
            pend_edge_q <= '0;
            int_q       <= 1'b0;
            intvn_q     <= 4'hF;
            win_ch_q    <= '0;
            act_ch_q    <= '0;
`ifdef V810_INTCTL_NEST_EN
            isr_q       <= '0;
`endif
        end else begin
            irq_q       <= irq_d;
            armed_q     <= armed_d;
            pend_edge_q <= pend_edge_d;
            int_q       <= int_d;
            intvn_q     <= intvn_d;
            win_ch_q    <= win_ch_d;
            act_ch_q    <= act_ch_d;
`ifdef V810_INTCTL_NEST_EN
            isr_q       <= isr_d;
`endif
        end
    end

    assign INT    = int_q;
    assign INTVn  = intvn_q;
    assign ACT_CH = act_ch_q;
    assign PEND   = pend;

endmodule

// File: tb/tb_v810_intctl.sv
// Directed bench for v810_intctl: a cycle model built from the priority/pending rules is
// compared every cycle, plus literal expectations at each test-plan point.
module tb_v810_intctl;

    localparam int NCH = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ce_s = 1'b1;
    logic [NCH-1:0]  irq_s = '0;
    logic [NCH-1:0]  edge_s = '1;
    logic [NCH-1:0]  mask_s = '0;
    logic [4*NCH-1:0] prio_s = '0;
    logic            ack_s = 1'b0;
    logic            eoi_s = 1'b0;
    logic            int_o;
    logic [3:0]      intvn_o;
    logic [2:0]      act_o;
    logic [NCH-1:0]  pend_o;

    int checks = 0;
    int failures = 0;

    v810_intctl #(.NCH(NCH)) dut (
        .CLK(clk), .RESn(rst_n), .CE(ce_s), .IRQ(irq_s), .EDGE(edge_s),
        .MASK(mask_s), .PRIO(prio_s), .ACK(ack_s), .EOI(eoi_s),
        .INT(int_o), .INTVn(intvn_o), .ACT_CH(act_o), .PEND(pend_o)
    );

    always #5 clk = ~clk;

    // Model state: previous IRQ sample, latched edge requests, presented channel, in-service levels.
    bit m_irqp[NCH];
    bit m_ep[NCH];
    bit m_armed = 1'b0;
    bit m_int = 1'b0;
    int m_win = 0;
    int m_wprio = 0;
    int m_act = 0;
    int m_isq[$];

    function automatic int prio_of(input int i);
        return int'(prio_s[4*i +: 4]);
    endfunction

    function automatic bit m_pend(input int i);
        return edge_s[i] ? m_ep[i] : m_irqp[i];
    endfunction

    function automatic logic [NCH-1:0] m_pend_vec();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_pend(i);
        return v;
    endfunction

    // Highest in-service level, -1 when nothing is in service.
    function automatic int m_thresh();
        int t;
        t = -1;
        foreach (m_isq[k]) if (m_isq[k] > t) t = m_isq[k];
        return t;
    endfunction

    // Walk priority levels from the top; within a level the first channel found wins.
    function automatic int m_pick();
        int th;
        th = -1;
`ifdef V810_INTCTL_NEST_EN
        th = m_thresh();
`endif
        for (int p = 15; p >= 0; p--) begin
            if (p > th) begin
                for (int i = 0; i < NCH; i++) begin
                    if (m_pend(i) && !mask_s[i] && prio_of(i) == p) return i;
                end
            end
        end
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_irqp[i] = 1'b0;
            m_ep[i] = 1'b0;
        end
        m_armed = 1'b0;
        m_int = 1'b0;
        m_win = 0;
        m_wprio = 0;
        m_act = 0;
        m_isq.delete();
    endtask

    task automatic model_step();
        int w;
        bit ack_ok;
        bit nep[NCH];
        if (!rst_n) begin
            m_reset();
            return;
        end
        if (!ce_s) return;
        ack_ok = ack_s && m_int;
        w = m_pick();
        for (int i = 0; i < NCH; i++) begin
            nep[i] = (m_armed && edge_s[i] && irq_s[i] && !m_irqp[i]) ||
                     (m_ep[i] && !(ack_ok && i == m_win));
        end
`ifdef V810_INTCTL_NEST_EN
        if (eoi_s && m_isq.size() > 0) begin
            int mi;
            mi = 0;
            foreach (m_isq[k]) if (m_isq[k] > m_isq[mi]) mi = k;
            m_isq.delete(mi);
        end
        if (ack_ok) m_isq.push_back(prio_of(m_win));
`endif
        if (ack_ok) m_act = m_win;
        m_int = (w >= 0);
        m_win = (w >= 0) ? w : 0;
        m_wprio = (w >= 0) ? prio_of(w) : 0;
        for (int i = 0; i < NCH; i++) begin
            m_irqp[i] = irq_s[i];
            m_ep[i] = nep[i];
        end
        m_armed = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("cyc_INT", 32'(int_o), 32'(m_int));
        chk("cyc_INTVn", 32'(intvn_o), m_int ? 32'(15 - m_wprio) : 32'hF);
        chk("cyc_ACT_CH", 32'(act_o), 32'(m_act));
        chk("cyc_PEND", 32'(pend_o), 32'(m_pend_vec()));
    end

    task automatic tick();
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic [NCH-1:0] v);
        irq_s = v;
        tick();
        irq_s = '0;
        tick();
    endtask

    task automatic ack_pulse();
        ack_s = 1'b1;
        tick();
        ack_s = 1'b0;
    endtask

    task automatic set_prio(input int ch, input int p);
        prio_s[4*ch +: 4] = 4'(p);
    endtask

    initial begin
        // Reset with every line high
        irq_s = 8'hFF;
        tick(); tick();
        chk("rst_INT", 32'(int_o), 32'h0);
        chk("rst_INTVn", 32'(intvn_o), 32'hF);
        chk("rst_PEND", 32'(pend_o), 32'h0);
        chk("rst_ACT_CH", 32'(act_o), 32'h0);
        irq_s = 8'h01;
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("release_high_no_edge", 32'(pend_o), 32'h0);
        irq_s = 8'h00;
        tick();
        irq_s = 8'h01;
        tick();
        chk("fresh_edge_PEND", 32'(pend_o), 32'h01);
        chk("fresh_edge_INT_lat", 32'(int_o), 32'h0);
        tick();
        chk("fresh_edge_INT", 32'(int_o), 32'h1);
        ack_pulse();
        chk("ack_ch0", 32'(act_o), 32'h0);
        irq_s = 8'h00;
        tick();
        chk("ch0_retired", 32'(int_o), 32'h0);

        // Edge arbitration
        set_prio(2, 5);
        set_prio(6, 9);
        pulse(8'h44);
        chk("arb_INTVn_ch6", 32'(intvn_o), 32'h6);
        ack_pulse();
        chk("arb_ACT_ch6", 32'(act_o), 32'h6);
        tick();
        chk("arb_INTVn_ch2", 32'(intvn_o), 32'hA);
        ack_pulse();
        chk("arb_ACT_ch2", 32'(act_o), 32'h2);
        tick();
        chk("arb_INT_idle", 32'(int_o), 32'h0);

        // Tie and mask
        set_prio(1, 7);
        set_prio(4, 7);
        pulse(8'h12);
        chk("tie_INTVn", 32'(intvn_o), 32'h8);
        mask_s = 8'h02;
        tick();
        chk("mask_PEND_kept", 32'(pend_o), 32'h12);
        chk("mask_INTVn", 32'(intvn_o), 32'h8);
        ack_pulse();
        chk("mask_ACT_ch4", 32'(act_o), 32'h4);
        tick();
        chk("mask_INT_blocked", 32'(int_o), 32'h0);
        mask_s = 8'h00;
        tick();
        ack_pulse();
        chk("unmask_ACT_ch1", 32'(act_o), 32'h1);
        tick(); tick();

        // Level mode
        edge_s[3] = 1'b0;
        set_prio(3, 4);
        irq_s = 8'h08;
        tick(); tick();
        chk("lvl_INT", 32'(int_o), 32'h1);
        chk("lvl_INTVn", 32'(intvn_o), 32'hB);
        ack_pulse();
        chk("lvl_ACT", 32'(act_o), 32'h3);
        tick(); tick();
        chk("lvl_INT_held", 32'(int_o), 32'h1);
        irq_s = 8'h00;
        tick();
        chk("lvl_INT_lat", 32'(int_o), 32'h1);
        tick();
        chk("lvl_INT_drop", 32'(int_o), 32'h0);
        ack_pulse();
        chk("ack_idle_ignored", 32'(act_o), 32'h3);

        // Re-trigger on the acknowledging edge
        pulse(8'h04);
        irq_s = 8'h04;
        ack_pulse();
        chk("coll_PEND", 32'(pend_o), 32'h04);
        irq_s = 8'h00;
        tick();
        chk("coll_INT", 32'(int_o), 32'h1);
        ack_pulse();
        tick();
        chk("coll_cleared", 32'(int_o), 32'h0);

        // Clock enable freeze
        pulse(8'h40);
        ce_s = 1'b0;
        ack_s = 1'b1;
        irq_s = 8'h02;
        tick(); tick();
        ack_s = 1'b0;
        irq_s = 8'h00;
        tick();
        chk("ce_ACT_frozen", 32'(act_o), 32'h2);
        chk("ce_PEND_frozen", 32'(pend_o), 32'h40);
        ce_s = 1'b1;
        ack_pulse();
        chk("ce_ACT_ch6", 32'(act_o), 32'h6);
        tick();

        // Reset mid-operation with CE low
        pulse(8'h40);
        chk("pre_rst_INT", 32'(int_o), 32'h1);
        rst_n = 1'b0;
        ce_s = 1'b0;
        #1;
        chk("midrst_INT", 32'(int_o), 32'h0);
        chk("midrst_INTVn", 32'(intvn_o), 32'hF);
        chk("midrst_PEND", 32'(pend_o), 32'h0);
        tick();
        rst_n = 1'b1;
        ce_s = 1'b1;
        tick(); tick();

        // Nesting
        set_prio(0, 3);
        set_prio(5, 3);
        set_prio(7, 8);
        pulse(8'h01);
        chk("nest_ch0_INTVn", 32'(intvn_o), 32'hC);
        ack_pulse();
        tick();
        pulse(8'h20);
`ifdef V810_INTCTL_NEST_EN
        chk("nest_equal_blocked", 32'(int_o), 32'h0);
`else
        chk("flat_equal_presented", 32'(int_o), 32'h1);
`endif
        pulse(8'h80);
        chk("nest_ch7_INT", 32'(int_o), 32'h1);
        chk("nest_ch7_INTVn", 32'(intvn_o), 32'h7);
        ack_pulse();
        chk("nest_ACT_ch7", 32'(act_o), 32'h7);
        eoi_s = 1'b1;
        tick(); tick();
        eoi_s = 1'b0;
        tick();
        chk("nest_ch5_INT", 32'(int_o), 32'h1);
        chk("nest_ch5_INTVn", 32'(intvn_o), 32'hC);
        ack_s = 1'b1;
        eoi_s = 1'b1;
        tick();
        ack_s = 1'b0;
        eoi_s = 1'b0;
        chk("nest_ACT_ch5", 32'(act_o), 32'h5);
        tick();
        chk("nest_idle", 32'(int_o), 32'h0);
        eoi_s = 1'b1;
        tick();
        eoi_s = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
